execute_branch_unit: RTL and testbench

EXECUTE_BRANCH_UNIT -- requirements
Module: execute_branch_unit

---
 rtl/execute_branch_unit.sv | 157 +++++++++++++++
 tb/tb_execute_branch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_branch_unit.sv
// -----------------------------------------------------------------------------
// execute_branch_unit
//
// Holds the ID/EX pipeline register for control-transfer instructions and
// resolves branches/jumps in the same cycle the instruction sits in E.
// Produces the fetch redirect (PCSrcE/PCTargetE), the decode squash (FlushD),
// the JAL/JALR link value (PCPlus4E), and two saturating statistics counters.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   ValidD     in   decode stage holds a real instruction
//   BranchD    in   conditional branch
//   JumpD      in   JAL or JALR
//   JalrD      in   JALR (implies JumpD)
//   Funct3D    in   branch condition code
//   RD1D/RD2D  in   register operands
//   ImmExtD    in   sign-extended immediate
//   PCD        in   decode PC
//   PCPlus4D   in   decode PC+4
//   StallE     in   hold the execute register
//   FlushE     in   squash the execute register
//   PCSrcE     out  redirect fetch this cycle
//   PCTargetE  out  redirect address
//   FlushD     out  squash fetch/decode register at the next edge
//   PCPlus4E   out  link value
//   BranchCnt  out  resolved control-transfer count (saturating)
//   TakenCnt   out  taken control-transfer count (saturating)
//
// Pipeline control: there is no valid/ready handshake. StallE holds every
// field of the E register and suppresses resolution; FlushE clears the control
// bits. A taken instruction resolves on the first cycle it is in E with
// StallE=0, redirects for that one cycle, and the following edge discards the
// wrong-path instruction coming from decode (self-kill).
// -----------------------------------------------------------------------------
module execute_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             JalrD,
  input  logic [2:0]       Funct3D,
  input  logic [31:0]      RD1D,
  input  logic [31:0]      RD2D,
  input  logic [31:0]      ImmExtD,
  input  logic [31:0]      PCD,
  input  logic [31:0]      PCPlus4D,
  input  logic             StallE,
  input  logic             FlushE,
  output logic             PCSrcE,
  output logic [31:0]      PCTargetE,
  output logic             FlushD,
  output logic [31:0]      PCPlus4E,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic        cond_e;
  logic        redirect;
  logic        resolve;
  logic [31:0] jalr_sum;

  // Branch condition on the registered operands.
  always_comb begin
    cond_e = 1'b0;
    case (ex_q.funct3)
      3'b000:  cond_e = (ex_q.rd1 == ex_q.rd2);
      3'b001:  cond_e = (ex_q.rd1 != ex_q.rd2);
      3'b100:  cond_e = ($signed(ex_q.rd1) <  $signed(ex_q.rd2));
      3'b101:  cond_e = ($signed(ex_q.rd1) >= $signed(ex_q.rd2));
      3'b110:  cond_e = (ex_q.rd1 <  ex_q.rd2);
      3'b111:  cond_e = (ex_q.rd1 >= ex_q.rd2);
      default: cond_e = 1'b0;
    endcase
  end

  // A stalled instruction is not resolved, so a taken branch defers its
  // redirect to the first unstalled cycle.
  assign redirect = ex_q.valid & ~StallE & (ex_q.jump | (ex_q.branch & cond_e));
  assign resolve  = ex_q.valid & ~StallE & (ex_q.branch | ex_q.jump);
  assign jalr_sum = ex_q.rd1 + ex_q.imm;

  assign PCSrcE    = redirect;
  assign FlushD    = redirect;
  assign PCTargetE = ex_q.jalr ? {jalr_sum[31:1], 1'b0} : (ex_q.pc + ex_q.imm);
  assign PCPlus4E  = ex_q.pc_plus4;
  assign BranchCnt = branch_cnt_q;
  assign TakenCnt  = taken_cnt_q;

  // E register next state: flush, then self-kill, then stall, then load.
  // Flush and self-kill only clear control bits; data fields hold.
  always_comb begin
    ex_d = ex_q;
    if (FlushE || redirect) begin
      ex_d.valid  = 1'b0;
      ex_d.branch = 1'b0;
      ex_d.jump   = 1'b0;
      ex_d.jalr   = 1'b0;
    end else if (!StallE) begin
      ex_d.valid    = ValidD;
      ex_d.branch   = BranchD;
      ex_d.jump     = JumpD;
      ex_d.jalr     = JalrD;
      ex_d.funct3   = Funct3D;
      ex_d.rd1      = RD1D;
      ex_d.rd2      = RD2D;
      ex_d.imm      = ImmExtD;
      ex_d.pc       = PCD;
      ex_d.pc_plus4 = PCPlus4D;
    end
  end

  // Saturating counters, independent of FlushE.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (resolve && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (redirect && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q         <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_execute_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_execute_branch_unit
//
// Directed bench for execute_branch_unit. Two instances share all inputs:
// u_dut with the default 16-bit counters and u_dut4 with 4-bit counters for
// the saturation case. Inputs change 1 time unit after a rising edge and
// outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_execute_branch_unit;

  logic        clk;
  logic        rst;
  logic        ValidD, BranchD, JumpD, JalrD;
  logic [2:0]  Funct3D;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic        StallE, FlushE;

  logic        pcsrc, flushd;
  logic [31:0] target, link;
  logic [15:0] bcnt, tcnt;

  logic        pcsrc4, flushd4;
  logic [31:0] target4, link4;
  logic [3:0]  bcnt4, tcnt4;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  execute_branch_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .ValidD(ValidD), .BranchD(BranchD), .JumpD(JumpD), .JalrD(JalrD),
    .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .StallE(StallE), .FlushE(FlushE),
    .PCSrcE(pcsrc), .PCTargetE(target), .FlushD(flushd), .PCPlus4E(link),
    .BranchCnt(bcnt), .TakenCnt(tcnt)
  );

  execute_branch_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .ValidD(ValidD), .BranchD(BranchD), .JumpD(JumpD), .JalrD(JalrD),
    .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .StallE(StallE), .FlushE(FlushE),
    .PCSrcE(pcsrc4), .PCTargetE(target4), .FlushD(flushd4), .PCPlus4E(link4),
    .BranchCnt(bcnt4), .TakenCnt(tcnt4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    ValidD = 1'b0; BranchD = 1'b0; JumpD = 1'b0; JalrD = 1'b0;
    Funct3D = 3'b000; RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
  endtask

  task automatic drive_instr(input logic br, input logic jmp, input logic jalr,
                             input logic [2:0] f3, input logic [31:0] rd1,
                             input logic [31:0] rd2, input logic [31:0] imm,
                             input logic [31:0] pc);
    ValidD = 1'b1; BranchD = br; JumpD = jmp; JalrD = jalr; Funct3D = f3;
    RD1D = rd1; RD2D = rd2; ImmExtD = imm; PCD = pc; PCPlus4D = pc + 32'd4;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    StallE = 1'b0;
    FlushE = 1'b0;
    drive_bubble();
    rst = 1'b0;

    // reset state
    #2;
    check("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("rst_flushd", {31'd0, flushd}, 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_link", link, 32'd0);
    check("rst_bcnt", {16'd0, bcnt}, 32'd0);
    check("rst_tcnt", {16'd0, tcnt}, 32'd0);
    step();
    rst = 1'b1;

    // BEQ taken; decode keeps presenting it to exercise self-kill
    drive_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100);
    step();
    check("beq_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("beq_target", target, 32'h120);
    check("beq_flushd", {31'd0, flushd}, 32'd1);
    step();
    check("beq_killed", {31'd0, pcsrc}, 32'd0);
    check("beq_tcnt", {16'd0, tcnt}, 32'd1);
    check("beq_bcnt", {16'd0, bcnt}, 32'd1);
    drive_bubble();
    step();

    // BLT signed: -1 < 1 taken
    drive_instr(1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200);
    step();
    check("blt_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("blt_target", target, 32'h210);
    drive_bubble();
    step();
    // BLTU unsigned: 0xFFFFFFFF < 1 false
    drive_instr(1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h210);
    step();
    check("bltu_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("bltu_bcnt_pre", {16'd0, bcnt}, 32'd2);
    drive_bubble();
    step();
    check("bltu_bcnt", {16'd0, bcnt}, 32'd3);
    check("bltu_tcnt", {16'd0, tcnt}, 32'd2);

    // JALR: target bit 0 cleared, link passed through
    drive_instr(1'b0, 1'b1, 1'b1, 3'b000, 32'h2003, 32'd0, 32'h4, 32'h40);
    step();
    check("jalr_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("jalr_target", target, 32'h2006);
    check("jalr_link", link, 32'h44);
    drive_bubble();
    step();
    check("jalr_bcnt", {16'd0, bcnt}, 32'd4);
    check("jalr_tcnt", {16'd0, tcnt}, 32'd3);

    // BNE taken, held two cycles by StallE
    drive_instr(1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h300);
    step();
    StallE = 1'b1;
    drive_bubble();
    #1;
    check("bne_stall1", {31'd0, pcsrc}, 32'd0);
    step();
    check("bne_stall2", {31'd0, pcsrc}, 32'd0);
    check("bne_stall_bcnt", {16'd0, bcnt}, 32'd4);
    check("bne_stall_tcnt", {16'd0, tcnt}, 32'd3);
    step();
    StallE = 1'b0;
    #1;
    check("bne_release", {31'd0, pcsrc}, 32'd1);
    check("bne_target", target, 32'h2F8);
    step();
    check("bne_once", {31'd0, pcsrc}, 32'd0);
    check("bne_tcnt", {16'd0, tcnt}, 32'd4);
    check("bne_bcnt", {16'd0, bcnt}, 32'd5);

    // JAL with FlushE in the same cycle: redirect still issued
    drive_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h100, 32'h400);
    step();
    FlushE = 1'b1;
    #1;
    check("flush_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("flush_target", target, 32'h500);
    step();
    FlushE = 1'b0;
    check("flush_cleared", {31'd0, pcsrc}, 32'd0);
    check("flush_tcnt", {16'd0, tcnt}, 32'd5);
    check("flush_bcnt", {16'd0, bcnt}, 32'd6);
    drive_bubble();
    step();

    // Funct3 010 never taken
    drive_instr(1'b1, 1'b0, 1'b0, 3'b010, 32'd7, 32'd7, 32'h8, 32'h500);
    step();
    check("f010_pcsrc", {31'd0, pcsrc}, 32'd0);
    drive_bubble();
    step();
    check("f010_bcnt", {16'd0, bcnt}, 32'd7);
    check("f010_tcnt", {16'd0, tcnt}, 32'd5);

    // asynchronous reset while redirecting
    drive_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h10, 32'h600);
    step();
    check("arst_pre", {31'd0, pcsrc}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("arst_flushd", {31'd0, flushd}, 32'd0);
    check("arst_target", target, 32'd0);
    check("arst_bcnt", {16'd0, bcnt}, 32'd0);
    check("arst_tcnt", {16'd0, tcnt}, 32'd0);
    check("arst_tcnt4", {28'd0, tcnt4}, 32'd0);
    drive_bubble();
    step();
    rst = 1'b1;
    step();

    // saturation: 20 taken jumps, every other edge self-kills
    pulse_reset();
    drive_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h10, 32'h700);
    for (int k = 1; k <= 40; k++) begin
      int n;
      step();
      n = (k / 2 > 15) ? 15 : k / 2;
      exp_q.push_back(32'(n));
      exp_q.push_back(32'(n));
      check("sat_tcnt4", {28'd0, tcnt4}, exp_q.pop_front());
      check("sat_bcnt4", {28'd0, bcnt4}, exp_q.pop_front());
    end
    drive_bubble();
    check("sat_tcnt16", {16'd0, tcnt}, 32'd20);
    check("sat_bcnt16", {16'd0, bcnt}, 32'd20);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
